regfile_pipe: RTL and testbench
===============================

Name: regfile_pipe

Overview:
- Parametrised successor to the 8x8 two-read/one-write register file.
- Generic data width and depth, single clock, registered write pipeline and optional read-after-write bypass.
- Optional hardwired-zero register 0, plus a sequential clear engine that sweeps the array one entry per cycle.
- Sits between the decode stage (read addresses) and the writeback stage (write port) of the datapath.

Parameters:
- DATA_W, 8, data bits per register.
- ADDR_W, 3, address bits; DEPTH = 2**ADDR_W entries (derived, not overridable).
- BYPASS, 1, when 1 a pending latched write is forwarded to matching read ports.
- ZERO_R0, 0, when 1 entry 0 is read-only and always reads 0.

Ports:
- clka  input  1  system clock, all state updates on rising edge.
- reset_in  input  1  asynchronous active-low reset.
- clear_in  input  1  synchronous request to start a clear sweep (sampled in IDLE only).
- stall_in  input  1  write inhibit; when 1 the write offered this cycle is discarded.
- we_reg_in  input  1  write enable.
- rd_in  input  ADDR_W  write address.
- data_in  input  DATA_W  write data.
- sr1_in  input  ADDR_W  read address, port 1.
- sr2_in  input  ADDR_W  read address, port 2.
- sr1_out  output  DATA_W  read data, port 1 (combinational).
- sr2_out  output  DATA_W  read data, port 2 (combinational).
- reg0_out  output  DATA_W  contents of entry 0 (combinational, includes bypass).
- busy_out  output  1  high while a clear sweep is in progress.

Behaviour:
- Reset (reset_in=0, async): all entries 0; write latch valid=0, address 0, data 0; FSM=IDLE; sweep pointer 0; busy_out=0. With an empty array, all read outputs are 0.
- Capture stage, edge N:
  - In IDLE with clear_in=0: wr_valid <= we_reg_in & ~stall_in; wr_addr <= rd_in; wr_data <= data_in.
  - Otherwise: wr_valid <= 0.
- Commit stage, edge N+1: if wr_valid, array[wr_addr] <= wr_data.
  - If ZERO_R0=1 and wr_addr=0, the commit is dropped.
- Write latency: data offered before edge N is in the array after edge N+1. Back-to-back writes every cycle are supported.
- Reads: srX_out = array[srX_in].
  - If BYPASS=1, wr_valid=1 and srX_in==wr_addr: srX_out = wr_data (forwarded one cycle early).
  - ZERO_R0=1 and address 0 always read 0, overriding bypass.
  - reg0_out follows the same rules with address 0.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP when clear_in=1 at an edge; pointer <= 0; busy_out <= 1.
  - In SWEEP, each edge: array[pointer] <= 0; pointer <= pointer+1.
  - When pointer==DEPTH-1 is written: -> IDLE, busy_out <= 0. busy_out is high for exactly DEPTH cycles.
  - clear_in in SWEEP is ignored, and the sweep is not restarted.
  - Writes offered while busy_out=1 or at the clear_in edge are discarded; stall_in is irrelevant then.
  - A write already latched (wr_valid=1) at the clear_in edge still commits at that edge; the sweep later zeroes it.
  - Reads during SWEEP return current array contents (partially cleared). Bypass never fires, since wr_valid=0.
- Pointer width ADDR_W; it wraps to 0 naturally on exit.
- Same-address write on consecutive cycles: the later one wins, and bypass shows the newest latched data.
- Reset asserted mid-sweep or mid-write: immediate return to the reset state; the array is fully zeroed regardless of sweep progress.
- No X on outputs after reset for any address.

Test Plan:
- Reset then write rd=3, data=0xA5 at edge 1 -> sr1_in=3 reads 0xA5 after edge 1 (bypass) and after edge 2 (array).
- Rerun with BYPASS=0 -> sr1_in=3 reads 0x00 after edge 1 and 0xA5 after edge 2.
- Write with stall_in=1 (rd=5, 0x3C) -> entry 5 stays 0x00. Same write with stall_in=0 -> 0x3C.
- Back-to-back writes rd=2: 0x11 then 0x22 -> sr2_in=2 reads 0x11 then 0x22 on consecutive cycles; final array value 0x22.
- Fill all 8 entries with 0x10+i, pulse clear_in with a concurrent write rd=4 data 0xFF -> busy_out high exactly 8 cycles; entry 4 never reads 0xFF; all entries 0 afterwards.
- Same fill, pulse clear_in while a write rd=1 data 0x77 is already latched -> 0x77 commits at the clear_in edge, then entry 1 is zeroed by the sweep.
- ZERO_R0=1: write rd=0 data 0x99 -> reg0_out and sr1_in=0 stay 0x00 throughout.
- Drop reset_in to 0 at sweep pointer 3 with entries 5..7 nonzero -> all entries 0, busy_out 0 immediately; clear_in afterwards starts a fresh 8-cycle sweep.

Source files
------------

// File: rtl/regfile_pipe.sv
// ---------------------------------------------------------------------------
// regfile_pipe
//
// Parametrised register file with two combinational read ports, one write
// port and a dedicated entry-0 output. Sits between decode (read addresses)
// and writeback (write port) of the datapath.
//
// A write is captured into a one-entry latch at one edge and committed into
// the array at the following edge. While the latch holds a pending write,
// reads of that address can optionally be forwarded from the latch so the
// value is visible one cycle before it lands in the array. Entry 0 can
// optionally be hardwired to zero. A clear engine zeroes the array one
// entry per cycle.
//
// Ports:
//   clka      in   1       system clock, rising edge
//   reset_in  in   1       asynchronous active-low reset
//   clear_in  in   1       start a clear sweep (sampled only while idle)
//   stall_in  in   1       discard the write offered this cycle
//   we_reg_in in   1       write enable
//   rd_in     in   ADDR_W  write address
//   data_in   in   DATA_W  write data
//   sr1_in    in   ADDR_W  read address, port 1
//   sr2_in    in   ADDR_W  read address, port 2
//   sr1_out   out  DATA_W  read data, port 1 (combinational)
//   sr2_out   out  DATA_W  read data, port 2 (combinational)
//   reg0_out  out  DATA_W  contents of entry 0 (combinational, with bypass)
//   busy_out  out  1       high while a clear sweep is running
// ---------------------------------------------------------------------------
module regfile_pipe #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 3,
   parameter int BYPASS  = 1,
   parameter int ZERO_R0 = 0
) (
   input  logic              clka,
   input  logic              reset_in,
   input  logic              clear_in,
   input  logic              stall_in,
   input  logic              we_reg_in,
   input  logic [ADDR_W-1:0] rd_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic [ADDR_W-1:0] sr1_in,
   input  logic [ADDR_W-1:0] sr2_in,
   output logic [DATA_W-1:0] sr1_out,
   output logic [DATA_W-1:0] sr2_out,
   output logic [DATA_W-1:0] reg0_out,
   output logic              busy_out
);

   localparam int DEPTH     = 1 << ADDR_W;
   localparam int NUM_READS = 3;   // sr1, sr2 and the entry-0 view

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_t;

   state_t              state_reg;
   logic [ADDR_W-1:0]   ptr_reg;
   logic                busy_reg;

   logic                wr_valid_reg;
   logic [ADDR_W-1:0]   wr_addr_reg;
   logic [DATA_W-1:0]   wr_data_reg;

   logic [DATA_W-1:0]   mem_reg [DEPTH];

   // New writes are only accepted while idle and not on the edge that
   // launches a sweep; otherwise the offered write is simply dropped.
   logic capture_ok;
   assign capture_ok = (state_reg == ST_IDLE) && !clear_in;

   // ------------------------------------------------------------------
   // Capture stage: write latch
   // ------------------------------------------------------------------
   always_ff @(posedge clka or negedge reset_in) begin
      if (!reset_in) begin
         wr_valid_reg <= 1'b0;
         wr_addr_reg  <= '0;
         wr_data_reg  <= '0;
      end else if (capture_ok) begin
         wr_valid_reg <= we_reg_in & ~stall_in;
         wr_addr_reg  <= rd_in;
         wr_data_reg  <= data_in;
      end else begin
         wr_valid_reg <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Clear sweep FSM; busy is registered so it is glitch-free and lines
   // up with the cycles in which the array is being swept.
   // ------------------------------------------------------------------
   always_ff @(posedge clka or negedge reset_in) begin
      if (!reset_in) begin
         state_reg <= ST_IDLE;
         ptr_reg   <= '0;
         busy_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (clear_in) begin
                  state_reg <= ST_SWEEP;
                  ptr_reg   <= '0;
                  busy_reg  <= 1'b1;
               end
            end
            ST_SWEEP: begin
               // Pointer wraps back to 0 on the final increment.
               ptr_reg <= ptr_reg + 1'b1;
               if (ptr_reg == {ADDR_W{1'b1}}) begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_out = busy_reg;

   // ------------------------------------------------------------------
   // Commit stage: one always_ff per entry. The sweep and a latched
   // write never target the same cycle in practice (the latch is always
   // empty during a sweep), but the sweep is given priority regardless.
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic sweep_hit;
         logic commit_hit;

         assign sweep_hit  = (state_reg == ST_SWEEP) && (ptr_reg == ADDR_W'(gi));
         // With a hardwired zero entry, commits to entry 0 are dropped.
         assign commit_hit = wr_valid_reg && (wr_addr_reg == ADDR_W'(gi))
                             && !((ZERO_R0 != 0) && (gi == 0));

         always_ff @(posedge clka or negedge reset_in) begin
            if (!reset_in) begin
               mem_reg[gi] <= '0;
            end else if (sweep_hit) begin
               mem_reg[gi] <= '0;
            end else if (commit_hit) begin
               mem_reg[gi] <= wr_data_reg;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Read ports. Zero-entry forcing overrides forwarding, which in turn
   // overrides the array contents.
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] rd_addr [NUM_READS];
   logic [DATA_W-1:0] rd_data [NUM_READS];

   assign rd_addr[0] = sr1_in;
   assign rd_addr[1] = sr2_in;
   assign rd_addr[2] = '0;

   generate
      for (genvar gi = 0; gi < NUM_READS; gi++) begin : g_read
         logic zero_hit;
         logic fwd_hit;

         assign zero_hit = (ZERO_R0 != 0) && (rd_addr[gi] == '0);
         assign fwd_hit  = (BYPASS != 0) && wr_valid_reg
                           && (rd_addr[gi] == wr_addr_reg);

         assign rd_data[gi] = zero_hit ? '0          :
                              fwd_hit  ? wr_data_reg :
                                         mem_reg[rd_addr[gi]];
      end
   endgenerate

   assign sr1_out  = rd_data[0];
   assign sr2_out  = rd_data[1];
   assign reg0_out = rd_data[2];

endmodule

// File: tb/tb_regfile_pipe.sv
// ---------------------------------------------------------------------------
// tb_regfile_pipe
//
// Directed bench for regfile_pipe. Three instances share the same stimulus:
//   dut_a : BYPASS=1, ZERO_R0=0 (default)
//   dut_b : BYPASS=0, ZERO_R0=0
//   dut_z : BYPASS=1, ZERO_R0=1
// Inputs are driven and outputs sampled 1 ns after the rising clock edge.
// ---------------------------------------------------------------------------
module tb_regfile_pipe;

   logic       clka;
   logic       reset_in;
   logic       clear_in;
   logic       stall_in;
   logic       we_reg_in;
   logic [2:0] rd_in;
   logic [7:0] data_in;
   logic [2:0] sr1_in;
   logic [2:0] sr2_in;

   logic [7:0] sr1_a, sr2_a, r0_a;
   logic       busy_a;
   logic [7:0] sr1_b, sr2_b, r0_b;
   logic       busy_b;
   logic [7:0] sr1_z, sr2_z, r0_z;
   logic       busy_z;

   int tests_run;
   int tests_failed;

   regfile_pipe #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_R0(0)) dut_a (
      .clka(clka), .reset_in(reset_in), .clear_in(clear_in), .stall_in(stall_in),
      .we_reg_in(we_reg_in), .rd_in(rd_in), .data_in(data_in),
      .sr1_in(sr1_in), .sr2_in(sr2_in),
      .sr1_out(sr1_a), .sr2_out(sr2_a), .reg0_out(r0_a), .busy_out(busy_a)
   );

   regfile_pipe #(.DATA_W(8), .ADDR_W(3), .BYPASS(0), .ZERO_R0(0)) dut_b (
      .clka(clka), .reset_in(reset_in), .clear_in(clear_in), .stall_in(stall_in),
      .we_reg_in(we_reg_in), .rd_in(rd_in), .data_in(data_in),
      .sr1_in(sr1_in), .sr2_in(sr2_in),
      .sr1_out(sr1_b), .sr2_out(sr2_b), .reg0_out(r0_b), .busy_out(busy_b)
   );

   regfile_pipe #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_R0(1)) dut_z (
      .clka(clka), .reset_in(reset_in), .clear_in(clear_in), .stall_in(stall_in),
      .we_reg_in(we_reg_in), .rd_in(rd_in), .data_in(data_in),
      .sr1_in(sr1_in), .sr2_in(sr2_in),
      .sr1_out(sr1_z), .sr2_out(sr2_z), .reg0_out(r0_z), .busy_out(busy_z)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   // Write entries i = 0..7 with 0x10+i, then let the last write commit.
   task automatic fill();
      for (int i = 0; i < 8; i++) begin
         we_reg_in = 1'b1;
         rd_in     = 3'(i);
         data_in   = 8'h10 + 8'(i);
         tick();
      end
      we_reg_in = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         sr1_in = 3'(i);
         sr2_in = 3'(i + 4);
         #1;
         tests_run++;
         if (sr1_a !== 8'h00 || sr2_a !== 8'h00 || sr1_z !== 8'h00 || sr2_b !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_read[%0d]: got a=%h/%h b=%h z=%h, want 00", i, sr1_a, sr2_a, sr2_b, sr1_z);
         end
      end
      tests_run++;
      if (busy_a !== 1'b0 || r0_a !== 8'h00 || r0_z !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_state: busy=%b r0=%h r0z=%h, want 0/00/00", busy_a, r0_a, r0_z);
      end
      $display("[TB] reset: outputs checked");
   endtask

   task automatic test_bypass();
      we_reg_in = 1'b1; rd_in = 3'd3; data_in = 8'hA5; sr1_in = 3'd3;
      tick();
      we_reg_in = 1'b0;
      tests_run++;
      if (sr1_a !== 8'hA5) begin
         tests_failed++;
         $display("FAIL bypass_early: got %h, want a5", sr1_a);
      end
      tests_run++;
      if (sr1_b !== 8'h00) begin
         tests_failed++;
         $display("FAIL nobypass_early: got %h, want 00", sr1_b);
      end
      tick();
      tests_run++;
      if (sr1_a !== 8'hA5 || sr1_b !== 8'hA5) begin
         tests_failed++;
         $display("FAIL write_commit: got a=%h b=%h, want a5", sr1_a, sr1_b);
      end
      $display("[TB] bypass: wrote 3<=a5");
   endtask

   task automatic test_stall();
      stall_in = 1'b1; we_reg_in = 1'b1; rd_in = 3'd5; data_in = 8'h3C; sr1_in = 3'd5;
      tick();
      stall_in = 1'b0; we_reg_in = 1'b0;
      tests_run++;
      if (sr1_a !== 8'h00) begin
         tests_failed++;
         $display("FAIL stall_bypass: got %h, want 00", sr1_a);
      end
      tick();
      tests_run++;
      if (sr1_a !== 8'h00 || sr1_b !== 8'h00) begin
         tests_failed++;
         $display("FAIL stall_commit: got a=%h b=%h, want 00", sr1_a, sr1_b);
      end
      we_reg_in = 1'b1;
      tick();
      we_reg_in = 1'b0;
      tick();
      tests_run++;
      if (sr1_a !== 8'h3C || sr1_b !== 8'h3C) begin
         tests_failed++;
         $display("FAIL unstalled_write: got a=%h b=%h, want 3c", sr1_a, sr1_b);
      end
      $display("[TB] stall: 5<=3c dropped then accepted");
   endtask

   task automatic test_back_to_back();
      sr2_in = 3'd2;
      we_reg_in = 1'b1; rd_in = 3'd2; data_in = 8'h11;
      tick();
      tests_run++;
      if (sr2_a !== 8'h11) begin
         tests_failed++;
         $display("FAIL b2b_first: got %h, want 11", sr2_a);
      end
      data_in = 8'h22;
      tick();
      we_reg_in = 1'b0;
      tests_run++;
      if (sr2_a !== 8'h22 || sr2_b !== 8'h11) begin
         tests_failed++;
         $display("FAIL b2b_second: got a=%h b=%h, want 22/11", sr2_a, sr2_b);
      end
      tick();
      tests_run++;
      if (sr2_a !== 8'h22 || sr2_b !== 8'h22) begin
         tests_failed++;
         $display("FAIL b2b_final: got a=%h b=%h, want 22", sr2_a, sr2_b);
      end
      $display("[TB] back_to_back: 2<=11,22");
   endtask

   task automatic test_clear_concurrent();
      int cnt;
      fill();
      for (int i = 0; i < 4; i++) begin
         sr1_in = 3'(i);
         sr2_in = 3'(i + 4);
         #1;
         tests_run++;
         if (sr1_a !== 8'h10 + 8'(i) || sr2_a !== 8'h14 + 8'(i)) begin
            tests_failed++;
            $display("FAIL fill[%0d]: got %h/%h, want %h/%h", i, sr1_a, sr2_a, 8'h10 + 8'(i), 8'h14 + 8'(i));
         end
      end
      clear_in = 1'b1; we_reg_in = 1'b1; rd_in = 3'd4; data_in = 8'hFF; sr1_in = 3'd4;
      tick();
      cnt = 0;
      // Keep offering the write during the sweep; every one must be dropped.
      while (busy_a === 1'b1 && cnt < 20) begin
         tests_run++;
         if (sr1_a === 8'hFF) begin
            tests_failed++;
            $display("FAIL clear_drop[%0d]: entry 4 got ff", cnt);
         end
         if (cnt == 2) clear_in = 1'b0;
         tick();
         cnt++;
      end
      we_reg_in = 1'b0; clear_in = 1'b0;
      tests_run++;
      if (cnt != 8) begin
         tests_failed++;
         $display("FAIL busy_len: got %0d cycles, want 8", cnt);
      end
      for (int i = 0; i < 4; i++) begin
         sr1_in = 3'(i);
         sr2_in = 3'(i + 4);
         #1;
         tests_run++;
         if (sr1_a !== 8'h00 || sr2_a !== 8'h00 || sr1_b !== 8'h00 || sr2_b !== 8'h00) begin
            tests_failed++;
            $display("FAIL cleared[%0d]: got a=%h/%h b=%h/%h, want 00", i, sr1_a, sr2_a, sr1_b, sr2_b);
         end
      end
      $display("[TB] clear_concurrent: busy %0d cycles", cnt);
   endtask

   task automatic test_clear_latched();
      int cnt;
      fill();
      we_reg_in = 1'b1; rd_in = 3'd1; data_in = 8'h77; sr1_in = 3'd1; sr2_in = 3'd5;
      tick();                      // write latched
      we_reg_in = 1'b0; clear_in = 1'b1;
      tick();                      // clear edge: latched write commits
      clear_in = 1'b0;
      tests_run++;
      if (sr1_a !== 8'h77 || sr1_b !== 8'h77 || busy_a !== 1'b1) begin
         tests_failed++;
         $display("FAIL latched_commit: got a=%h b=%h busy=%b, want 77/77/1", sr1_a, sr1_b, busy_a);
      end
      tick();                      // entry 0 swept
      tests_run++;
      if (sr1_a !== 8'h77) begin
         tests_failed++;
         $display("FAIL latched_hold: got %h, want 77", sr1_a);
      end
      tick();                      // entry 1 swept
      tests_run++;
      if (sr1_a !== 8'h00 || sr2_a !== 8'h15) begin
         tests_failed++;
         $display("FAIL partial_sweep: got e1=%h e5=%h, want 00/15", sr1_a, sr2_a);
      end
      cnt = 0;
      while (busy_a === 1'b1 && cnt < 20) begin
         tick();
         cnt++;
      end
      tests_run++;
      if (cnt != 6 || sr2_a !== 8'h00) begin
         tests_failed++;
         $display("FAIL latched_sweep_end: got %0d more cycles e5=%h, want 6/00", cnt, sr2_a);
      end
      $display("[TB] clear_latched: 1<=77 then swept");
   endtask

   task automatic test_zero_r0();
      we_reg_in = 1'b1; rd_in = 3'd0; data_in = 8'h99; sr1_in = 3'd0;
      tick();
      we_reg_in = 1'b0;
      tests_run++;
      if (sr1_z !== 8'h00 || r0_z !== 8'h00 || r0_a !== 8'h99) begin
         tests_failed++;
         $display("FAIL zero_r0_early: got z=%h r0z=%h r0a=%h, want 00/00/99", sr1_z, r0_z, r0_a);
      end
      tick();
      tests_run++;
      if (sr1_z !== 8'h00 || r0_z !== 8'h00 || sr1_a !== 8'h99 || r0_b !== 8'h99) begin
         tests_failed++;
         $display("FAIL zero_r0_late: got z=%h r0z=%h a=%h r0b=%h, want 00/00/99/99", sr1_z, r0_z, sr1_a, r0_b);
      end
      $display("[TB] zero_r0: 0<=99");
   endtask

   task automatic test_reset_mid_sweep();
      int cnt;
      fill();
      sr1_in = 3'd5;
      clear_in = 1'b1;
      tick();                      // sweep starts, pointer 0
      clear_in = 1'b0;
      tick(); tick(); tick();      // entries 0..2 cleared, pointer 3
      tests_run++;
      if (sr1_a !== 8'h15 || busy_a !== 1'b1) begin
         tests_failed++;
         $display("FAIL pre_reset: got e5=%h busy=%b, want 15/1", sr1_a, busy_a);
      end
      #2;
      reset_in = 1'b0;
      #1;
      tests_run++;
      if (busy_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_busy: got %b, want 0", busy_a);
      end
      for (int i = 0; i < 4; i++) begin
         sr1_in = 3'(i);
         sr2_in = 3'(i + 4);
         #1;
         tests_run++;
         if (sr1_a !== 8'h00 || sr2_a !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_clear[%0d]: got %h/%h, want 00", i, sr1_a, sr2_a);
         end
      end
      tick();
      reset_in = 1'b1;
      tick();
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      cnt = 0;
      while (busy_a === 1'b1 && cnt < 20) begin
         tick();
         cnt++;
      end
      tests_run++;
      if (cnt != 8) begin
         tests_failed++;
         $display("FAIL fresh_sweep: busy %0d cycles, want 8", cnt);
      end
      $display("[TB] reset_mid_sweep: fresh sweep %0d cycles", cnt);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset_in  = 1'b0;
      clear_in  = 1'b0;
      stall_in  = 1'b0;
      we_reg_in = 1'b0;
      rd_in     = '0;
      data_in   = '0;
      sr1_in    = '0;
      sr2_in    = '0;
      tick();
      tick();
      test_reset();
      reset_in = 1'b1;
      tick();
      test_bypass();
      test_stall();
      test_back_to_back();
      test_clear_concurrent();
      test_clear_latched();
      test_zero_r0();
      test_reset_mid_sweep();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
